// File: rtl/lfsr_seq_ctrl.sv
// Command-driven sequencer for a 16-bit Fibonacci LFSR with zero-lock recovery (8-in/8-out pad ring).
// Optional feature macro: LFSR_SEQ_ABORT_EN (GO while busy aborts back to IDLE).
module lfsr_seq_ctrl #(
  parameter int          LFSR_W = 16,
  parameter logic [15:0] TAPS   = 16'hB400,
  parameter int          LEN_W  = 8
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_SEED = 2'b01;
  localparam logic [1:0] CMD_LEN  = 2'b10;
  localparam logic [1:0] CMD_GO   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  logic             clk_s;
  logic             rst_s;
  logic [1:0]       cmd_s;
  logic [3:0]       data_s;

  state_t           state_r;
  logic [LFSR_W-1:0] lfsr_r;
  logic [LFSR_W-1:0] seed_r;
  logic [LEN_W-1:0] len_r;
  logic [1:0]       rsel_r;
  logic [LEN_W-1:0] cnt_r;
  logic             done_r;

  state_t           state_nxt_s;
  logic [LFSR_W-1:0] lfsr_nxt_s;
  logic [LFSR_W-1:0] seed_nxt_s;
  logic [LEN_W-1:0] len_nxt_s;
  logic [1:0]       rsel_nxt_s;
  logic [LEN_W-1:0] cnt_nxt_s;
  logic             done_nxt_s;
  logic             busy_s;
  logic [5:0]       window_s;

  assign clk_s  = io_in[0];
  assign rst_s  = io_in[1];
  assign cmd_s  = io_in[3:2];
  assign data_s = io_in[7:4];

  // An all-zero register would lock up, so the feedback bit is forced to 1 there.
  function automatic logic fb_bit(input logic [LFSR_W-1:0] v);
    logic par;
    par = ^(v & TAPS);
    return par | (v == {LFSR_W{1'b0}});
  endfunction

  // State register bank with synchronous reset.
  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      state_r <= IDLE;
      lfsr_r  <= {LFSR_W{1'b0}};
      seed_r  <= {LFSR_W{1'b0}};
      len_r   <= LEN_W'(1);
      rsel_r  <= 2'd0;
      cnt_r   <= {LEN_W{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      lfsr_r  <= lfsr_nxt_s;
      seed_r  <= seed_nxt_s;
      len_r   <= len_nxt_s;
      rsel_r  <= rsel_nxt_s;
      cnt_r   <= cnt_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Next-state logic: command decode in IDLE, serial seed load, then N LFSR steps.
  always_comb begin
    state_nxt_s = state_r;
    lfsr_nxt_s  = lfsr_r;
    seed_nxt_s  = seed_r;
    len_nxt_s   = len_r;
    rsel_nxt_s  = rsel_r;
    cnt_nxt_s   = cnt_r;
    done_nxt_s  = done_r;
    case (state_r)
      IDLE: begin
        case (cmd_s)
          CMD_NOP:  rsel_nxt_s = data_s[1:0];
          CMD_SEED: begin
            seed_nxt_s = {seed_r[LFSR_W-5:0], data_s};
            done_nxt_s = 1'b0;
          end
          CMD_LEN: begin
            len_nxt_s  = {len_r[LEN_W-5:0], data_s};
            done_nxt_s = 1'b0;
          end
          CMD_GO: begin
            done_nxt_s  = 1'b0;
            cnt_nxt_s   = {LEN_W{1'b0}};
            state_nxt_s = LOAD;
          end
          default: state_nxt_s = IDLE;
        endcase
      end
      LOAD: begin
        lfsr_nxt_s = {lfsr_r[LFSR_W-2:0], seed_r[4'd15 - cnt_r[3:0]]};
        if (cnt_r == LEN_W'(15)) begin
          cnt_nxt_s   = {LEN_W{1'b0}};
          state_nxt_s = RUN;
        end else begin
          cnt_nxt_s   = cnt_r + LEN_W'(1);
        end
      end
      RUN: begin
        lfsr_nxt_s = {lfsr_r[LFSR_W-2:0], fb_bit(lfsr_r)};
        cnt_nxt_s  = cnt_r + LEN_W'(1);
        // len==0 makes len-1 wrap to 255, giving the 256-step burst for free.
        if (cnt_r == (len_r - LEN_W'(1))) begin
          state_nxt_s = IDLE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
`ifdef LFSR_SEQ_ABORT_EN
    if ((state_r != IDLE) && (cmd_s == CMD_GO)) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = {LEN_W{1'b0}};
      lfsr_nxt_s  = lfsr_r;
      done_nxt_s  = done_r;
    end else begin
      rsel_nxt_s  = rsel_nxt_s;
    end
`endif
  end

  assign busy_s = (state_r != IDLE);

  // Readback window selection, live in every state.
  always_comb begin
    window_s = 6'd0;
    case (rsel_r)
      2'd0:    window_s = lfsr_r[5:0];
      2'd1:    window_s = lfsr_r[11:6];
      2'd2:    window_s = {2'b00, lfsr_r[15:12]};
      2'd3:    window_s = cnt_r[5:0];
      default: window_s = 6'd0;
    endcase
  end

  assign io_out = {busy_s, done_r, window_s};

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Scoreboard bench for lfsr_seq_ctrl: a transaction-level model queues expected burst/readback
// results; a negedge monitor pops and compares whenever a burst ends or a readback is strobed.
module tb_lfsr_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cmd = 2'b00;
  logic [3:0] data = 4'h0;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic       rd_strobe = 1'b0;

  assign io_in = {data, cmd, rst, clk};

  always #5 clk = ~clk;

  lfsr_seq_ctrl dut (.io_in(io_in), .io_out(io_out));

  typedef struct {
    bit         is_burst;
    int         len;
    logic [7:0] out;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [15:0] m_seed = 16'h0000;
  logic [15:0] m_lfsr = 16'h0000;
  logic [7:0]  m_len  = 8'h01;
  logic [1:0]  m_rsel = 2'd0;
  bit          m_done = 1'b0;

  // Result of stepping the polynomial 'steps' times from 'start'.
  function automatic logic [15:0] ref_run(input logic [15:0] start, input int steps);
    logic [15:0] v;
    bit          fb;
    v = start;
    for (int i = 0; i < steps; i++) begin
      fb = (($countones(v & 16'hB400) % 2) == 1) || (v == 16'h0000);
      v  = {v[14:0], fb};
    end
    return v;
  endfunction

  // Window model; select 3 is only checked where the counter is known to be zero.
  function automatic logic [5:0] ref_win(input logic [15:0] l, input logic [1:0] sel);
    case (sel)
      2'd0:    return l[5:0];
      2'd1:    return l[11:6];
      2'd2:    return {2'b00, l[15:12]};
      default: return 6'h00;
    endcase
  endfunction

  // Monitor: measures each busy window and checks the outputs right after it and on strobes.
  initial begin
    int   busy_len;
    logic prev_busy;
    exp_t e;
    busy_len  = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (io_out[7] === 1'b1) begin
        busy_len++;
      end else if (prev_busy) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL burst_end: got len=%0d out=%h, want a queued burst expectation", busy_len, io_out);
        end else begin
          e = sb.pop_front();
          if (!e.is_burst || e.len != busy_len || io_out !== e.out) begin
            miscompares++;
            $display("FAIL burst_end: got len=%0d out=%h, want burst len=%0d out=%h",
                     busy_len, io_out, e.len, e.out);
          end
        end
        busy_len = 0;
      end
      if (rd_strobe) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL readback: got out=%h, want a queued readback expectation", io_out);
        end else begin
          e = sb.pop_front();
          if (e.is_burst || io_out !== e.out) begin
            miscompares++;
            $display("FAIL readback: got out=%h, want out=%h (kind burst=%0d)", io_out, e.out, e.is_burst);
          end
        end
      end
      prev_busy = (io_out[7] === 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic [3:0] d);
    cmd  = c;
    data = d;
    tick();
    cmd  = 2'b00;
    data = {2'b00, m_rsel};
  endtask

  task automatic model_reset();
    m_seed = 16'h0000;
    m_lfsr = 16'h0000;
    m_len  = 8'h01;
    m_rsel = 2'd0;
    m_done = 1'b0;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    cmd  = 2'b00;
    data = 4'h0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic seed_nib(input logic [3:0] d);
    m_seed = {m_seed[11:0], d};
    m_done = 1'b0;
    drive(2'b01, d);
  endtask

  task automatic len_nib(input logic [3:0] d);
    m_len  = {m_len[3:0], d};
    m_done = 1'b0;
    drive(2'b10, d);
  endtask

  task automatic set_rsel(input logic [1:0] sel);
    m_rsel = sel;
    drive(2'b00, {2'b00, sel});
  endtask

  task automatic strobe(input logic [7:0] exp_out);
    exp_t e;
    e.is_burst = 1'b0;
    e.len      = 0;
    e.out      = exp_out;
    sb.push_back(e);
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
  endtask

  task automatic check_out();
    strobe({1'b0, m_done, ref_win(m_lfsr, m_rsel)});
  endtask

  task automatic push_burst(input int len, input logic [7:0] out);
    exp_t e;
    e.is_burst = 1'b1;
    e.len      = len;
    e.out      = out;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input bit noise);
    int n;
    n = 0;
    while (io_out[7] === 1'b1 && n < 400) begin
      if (noise && $urandom_range(0, 3) == 0) begin
        cmd  = 2'($urandom_range(0, 2));
        data = 4'($urandom);
      end else begin
        cmd  = 2'b00;
        data = {2'b00, m_rsel};
      end
      tick();
      n++;
    end
    cmd  = 2'b00;
    data = {2'b00, m_rsel};
    if (n >= 400) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_timeout: got busy still 1 after %0d cycles, want 0", n);
    end
  endtask

  task automatic go_burst(input bit noise);
    int steps;
    steps  = (m_len == 8'h00) ? 256 : int'(m_len);
    m_lfsr = ref_run(m_seed, steps);
    m_done = 1'b1;
    push_burst(16 + steps, {1'b0, 1'b1, ref_win(m_lfsr, m_rsel)});
    drive(2'b11, 4'h0);
    wait_idle(noise);
  endtask

  // Reset asserted during busy cycle k (cycle 1 is the one right after GO).
  task automatic go_with_reset(input int k);
    push_burst(k, 8'h00);
    drive(2'b11, 4'h0);
    repeat (k - 1) tick();
    rst  = 1'b1;
    data = 4'h0;
    model_reset();
    tick();
    rst = 1'b0;
    wait_idle(1'b0);
  endtask

  // Second GO during busy cycle k.
  task automatic go_twice(input int k);
`ifdef LFSR_SEQ_ABORT_EN
    int sh;
    sh     = k - 1;
    m_lfsr = 16'((m_lfsr << sh) | (m_seed >> (16 - sh)));
    m_done = 1'b0;
    push_burst(k, {2'b00, ref_win(m_lfsr, m_rsel)});
`else
    int steps;
    steps  = (m_len == 8'h00) ? 256 : int'(m_len);
    m_lfsr = ref_run(m_seed, steps);
    m_done = 1'b1;
    push_burst(16 + steps, {1'b0, 1'b1, ref_win(m_lfsr, m_rsel)});
`endif
    drive(2'b11, 4'h0);
    repeat (k - 1) tick();
    drive(2'b11, 4'h0);
    wait_idle(1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of run, want $finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, including the counter view.
    do_reset();
    check_out();
    set_rsel(2'd3);
    check_out();
    set_rsel(2'd0);

    // Known-answer burst: seed ACE1, one step -> 59C3.
    seed_nib(4'hA); seed_nib(4'hC); seed_nib(4'hE); seed_nib(4'h1);
    len_nib(4'h0); len_nib(4'h1);
    go_burst(1'b0);
    strobe({1'b0, 1'b1, 6'h03});
    set_rsel(2'd1);
    strobe({1'b0, 1'b1, 6'h27});
    set_rsel(2'd2);
    strobe({1'b0, 1'b1, 6'h05});
    set_rsel(2'd0);

    // Commands during busy are ignored; a repeat GO reproduces the result.
    go_burst(1'b1);
    check_out();
    go_burst(1'b0);
    strobe({1'b0, 1'b1, 6'h03});

    // Zero seed recovers from lock-up.
    do_reset();
    seed_nib(4'h0); seed_nib(4'h0); seed_nib(4'h0); seed_nib(4'h0);
    len_nib(4'h0); len_nib(4'h1);
    go_burst(1'b0);
    strobe({1'b0, 1'b1, 6'h01});

    // len 0 means 256 steps.
    len_nib(4'h0); len_nib(4'h0);
    go_burst(1'b0);
    check_out();

    // Reset mid-LOAD and mid-RUN, then a normal burst again.
    do_reset();
    seed_nib(4'hA); seed_nib(4'hC); seed_nib(4'hE); seed_nib(4'h1);
    go_with_reset(8);
    check_out();
    seed_nib(4'hA); seed_nib(4'hC); seed_nib(4'hE); seed_nib(4'h1);
    len_nib(4'h0); len_nib(4'h5);
    go_with_reset(19);
    check_out();
    seed_nib(4'hA); seed_nib(4'hC); seed_nib(4'hE); seed_nib(4'h1);
    go_burst(1'b0);
    strobe({1'b0, 1'b1, 6'h03});

    // Second GO on busy cycle 5.
    go_twice(5);
    check_out();
`ifdef LFSR_SEQ_ABORT_EN
    set_rsel(2'd3);
    check_out();
    set_rsel(2'd0);
`endif

    // Randomized bursts.
    for (int it = 0; it < 12; it++) begin
      for (int j = 0; j < 4; j++) seed_nib(4'($urandom));
      len_nib(4'($urandom_range(0, 3)));
      len_nib(4'($urandom));
      set_rsel(2'($urandom_range(0, 2)));
      go_burst(1'($urandom_range(0, 1)));
      set_rsel(2'($urandom_range(0, 2)));
      check_out();
    end

    tick();
    tick();
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL leftover: got %0d unconsumed expectations, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
Command-driven sequencer for a 16-bit Fibonacci LFSR with zero-lock recovery, built as a Tiny Tapeout user module on the 8-in/8-out pad ring.
- Host writes a seed and a burst length nibble by nibble, then issues GO.
- Controller shifts the seed serially into the LFSR over 16 clocks, steps it N times, and flags completion.
- Readback exposes the LFSR state through a 6-bit window.

Parameters:
LFSR_W, 16, LFSR and seed register width (only 16 supported).
TAPS, 16'hB400, feedback mask (bits 15,13,12,10; x^16+x^14+x^13+x^11+1).
LEN_W, 8, burst length register width.

Ports:
io_in[0]  input  1  clk; all state updates on rising edge.
io_in[1]  input  1  rst; synchronous, active-high.
io_in[3:2]  input  2  cmd: 00 NOP/RSEL, 01 SEED nibble, 10 LEN nibble, 11 GO.
io_in[7:4]  input  4  data nibble for cmd.
io_out[7]  output  1  busy.
io_out[6]  output  1  done (sticky).
io_out[5:0]  output  6  readback window of LFSR.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, lfsr=0, seed=0, len=8'h01, rsel=0, cnt=0, busy=0, done=0. Reset wins over any cmd in any state, including mid-LOAD and mid-RUN.
- cmd is level-sampled every edge. The host holds a command for exactly one cycle per action.
- IDLE, commands execute in one cycle:
  - NOP: rsel <= data[1:0]; done unchanged.
  - SEED: seed <= {seed[11:0], data}; done <= 0.
  - LEN: len <= {len[3:0], data}; done <= 0.
  - GO: done <= 0; cnt <= 0; state <= LOAD.
- LOAD, 16 cycles:
  - Each cycle: lfsr <= {lfsr[14:0], seed[15-cnt]}, MSB first; cnt++.
  - After the 16th shift, lfsr == seed; cnt <= 0; state <= RUN.
  - seed register is not modified.
- RUN, N cycles, N = len, with len==0 meaning 256:
  - Each cycle: fb = ^(lfsr & TAPS); if lfsr==0, fb forced to 1.
  - lfsr <= {lfsr[14:0], fb}.
  - After the Nth step: state <= IDLE, done <= 1.
- busy = (state != IDLE), derived combinationally from the registered state. busy is asserted for exactly 16+N cycles starting the cycle after GO.
- While busy, SEED/LEN/NOP are ignored: seed, len and rsel are unchanged. GO is ignored unless LFSR_SEQ_ABORT_EN is defined.
- done is set in the same edge that returns to IDLE. It is cleared by a SEED, LEN or GO accepted in IDLE, or by reset.
- Readback, combinational from registers:
  - rsel 0 -> lfsr[5:0]
  - rsel 1 -> lfsr[11:6]
  - rsel 2 -> {2'b00, lfsr[15:12]}
  - rsel 3 -> {cnt[5:0]}
  - The window is valid in every state; it tracks the LFSR live during LOAD/RUN.
- cnt is 8 bits wide and wraps only through the explicit clears above.

Optional Feature:
LFSR_SEQ_ABORT_EN
- Defined: GO while busy aborts. Next state is IDLE, cnt <= 0, lfsr holds its current value, done stays 0. Abort on the final RUN cycle takes priority over completion, so done stays 0.
- Undefined: GO while busy is ignored. Logic is removed.

Test Plan:
1. Reset, then SEED A,C,E,1; LEN 0,1; GO -> busy=1 for exactly 17 cycles; then done=1, lfsr=16'h59C3. Readback: rsel0 -> 6'h03, rsel1 -> 6'h27, rsel2 -> 6'h05.
2. Reset, then SEED 0,0,0,0; LEN 0,1; GO -> zero-lock recovery; final lfsr=16'h0001, done=1.
3. LEN 0,0; GO -> busy for 272 cycles (len=0 encodes 256 steps); done rises on cycle 272.
4. During RUN, issue SEED F and LEN 3; after done, GO with len unchanged -> identical result to the prior run, proving seed and len were unaffected.
5. Assert rst mid-LOAD (cycle 8) and mid-RUN -> next cycle busy=0, done=0, readback rsel0 = 0; a subsequent SEED/GO sequence behaves as in test 1.
6. With LFSR_SEQ_ABORT_EN defined: GO, then GO again on busy cycle 5 -> busy=0 next cycle, done=0, lfsr holds its partially loaded value. Without the macro: the second GO is ignored and the full 17-cycle burst completes.
